// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default header tag base and an index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAG    = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_e;

    localparam logic [7:0] TAG_BASE_DEF = 8'hA0;

    // Index width for n sources; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the sources, the arbiter and the UART TX shifter.
// master: arbiter view; slave: the sources and transmitter around it.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_ptr+1,
// wrapping modulo NUM_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_ptr,
    output logic [GW-1:0]      pick,
    output logic               any
);

    logic [GW-1:0] idx_s;
    logic          hit_s;

    // Scan sources in rotating priority order and keep the first hit.
    always_comb begin
        pick  = '0;
        any   = 1'b0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = GW'((int'(last_ptr) + 32'sd1 + i) % NUM_REQ);
            hit_s = req[idx_s] & ~any;
            pick  = hit_s ? idx_s : pick;
            any   = any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte transmitter.
// Define UART_ARB_TAG_EN to prefix every packet with header TAG_BASE|grant_id.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
`ifdef UART_ARB_TAG_EN
    ,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
`endif
) (
    input  logic                       clk_50MHz,
    input  logic                       reset,
    uart_tx_arbiter_if.master          bus,
    output logic [idx_w(NUM_REQ)-1:0]  grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int            GW       = idx_w(NUM_REQ);
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    arb_state_e         state_r, state_nx_s;
    logic [GW-1:0]      grant_r, grant_nx_s;
    logic [GW-1:0]      last_ptr_r, last_ptr_nx_s;
    logic [CW-1:0]      idle_cnt_r, idle_cnt_nx_s;
    logic [GW-1:0]      pick_s;
    logic               any_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               tx_valid_s;
    logic [7:0]         tx_data_s;
    logic               timeout_s;
    logic               cur_valid_s;
    logic               cur_last_s;
    logic [7:0]         cur_data_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req      (bus.req_valid),
        .last_ptr (last_ptr_r),
        .pick     (pick_s),
        .any      (any_s)
    );

    assign cur_valid_s = bus.req_valid[grant_r];
    assign cur_last_s  = bus.req_last[grant_r];
    assign cur_data_s  = bus.req_data[{grant_r, 3'b000} +: 8];

    // State, grant, rotation pointer and idle counter registers.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            last_ptr_r <= GW'(NUM_REQ - 1);
            idle_cnt_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            grant_r    <= grant_nx_s;
            last_ptr_r <= last_ptr_nx_s;
            idle_cnt_r <= idle_cnt_nx_s;
        end
    end

    // Next-state and output decode; STREAM is a zero-latency pass-through.
    always_comb begin
        state_nx_s    = state_r;
        grant_nx_s    = grant_r;
        last_ptr_nx_s = last_ptr_r;
        idle_cnt_nx_s = idle_cnt_r;
        req_ready_s   = '0;
        tx_valid_s    = 1'b0;
        tx_data_s     = 8'h00;
        timeout_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    grant_nx_s    = pick_s;
                    last_ptr_nx_s = pick_s;
                    idle_cnt_nx_s = '0;
`ifdef UART_ARB_TAG_EN
                    state_nx_s    = ST_TAG;
`else
                    state_nx_s    = ST_STREAM;
`endif
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_valid_s = 1'b1;
                tx_data_s  = TAG_BASE | 8'(grant_r);
                if (bus.tx_ready) begin
                    state_nx_s    = ST_STREAM;
                    idle_cnt_nx_s = '0;
                end else begin
                    state_nx_s    = ST_TAG;
                end
            end
`endif
            ST_STREAM: begin
                tx_valid_s           = cur_valid_s;
                tx_data_s            = cur_data_s;
                req_ready_s[grant_r] = bus.tx_ready;
                if (cur_valid_s && bus.tx_ready) begin
                    idle_cnt_nx_s = '0;
                    state_nx_s    = cur_last_s ? ST_IDLE : ST_STREAM;
                end else if (!cur_valid_s) begin
                    if (idle_cnt_r == CNT_LAST) begin
                        timeout_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        // A stalled source with valid held never reaches here.
                        idle_cnt_nx_s = (idle_cnt_r == CNT_MAX) ? idle_cnt_r
                                                                : idle_cnt_r + CW'(1'b1);
                    end
                end else begin
                    idle_cnt_nx_s = idle_cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.tx_valid   = tx_valid_s;
    assign bus.tx_data    = tx_data_s;
    assign grant_id       = grant_r;
    assign busy           = (state_r != ST_IDLE);
    assign timeout_pulse  = timeout_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven sources, a packet-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int         NUM = 4;
    localparam int         T   = 8;
    localparam logic [7:0] TB_TAG_BASE = 8'hA0;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         gap;
    } item_t;

    logic             clk;
    logic             reset;
    logic [NUM-1:0]   rv;
    logic [8*NUM-1:0] rd;
    logic [NUM-1:0]   rl;
    logic             txr;
    logic [1:0]       gid;
    logic             busy;
    logic             to_p;

    item_t      q[NUM][$];
    int         wait_cnt[NUM];
    bit         flush_req;
    int         tx_mode;
    int         n_checks;
    int         n_fail;
    logic [7:0] byte_log[$];
    int         grant_log[$];
    logic [7:0] exp_q[$];
    int         cyc;
    int         to_cyc;
    int         src2_cyc;

    uart_tx_arbiter_if #(.NUM_REQ(NUM)) bus ();

    assign bus.req_valid = rv;
    assign bus.req_data  = rd;
    assign bus.req_last  = rl;
    assign bus.tx_ready  = txr;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_50MHz     (clk),
        .reset         (reset),
        .bus           (bus),
        .grant_id      (gid),
        .busy          (busy),
        .timeout_pulse (to_p)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bytes(input string name);
        chk({name, "_len"}, byte_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < byte_log.size(); i++)
            chk(name, {24'h0, byte_log[i]}, {24'h0, exp_q[i]});
    endtask

    task automatic push(input int s, input logic [7:0] d, input bit last, input int gap);
        item_t it;
        it.d = d;
        it.last = last;
        it.gap = gap;
        q[s].push_back(it);
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NUM; i++)
            if (q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (c < maxc && !(all_empty() && rv == '0 && busy == 1'b0)) begin
            step();
            c++;
        end
        chk("drain_done", {31'h0, c < maxc}, 32'h1);
        step();
        step();
    endtask

    // Source engine: each source presents its queued bytes and holds them until accepted.
    initial begin
        logic [NUM-1:0] acc;
        rv = '0;
        rd = '0;
        rl = '0;
        txr = 1'b1;
        for (int i = 0; i < NUM; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            acc = rv & bus.req_ready;
            @(posedge clk);
            #1;
            if (flush_req) begin
                for (int i = 0; i < NUM; i++) begin
                    q[i].delete();
                    wait_cnt[i] = 0;
                end
                rv = '0;
                flush_req = 1'b0;
            end else begin
                for (int i = 0; i < NUM; i++) begin
                    if (acc[i]) begin
                        void'(q[i].pop_front());
                        rv[i] = 1'b0;
                    end
                    if (!rv[i] && q[i].size() > 0) begin
                        if (wait_cnt[i] >= q[i][0].gap) begin
                            rv[i] = 1'b1;
                            rd[8*i +: 8] = q[i][0].d;
                            rl[i] = q[i][0].last;
                            wait_cnt[i] = 0;
                        end else begin
                            wait_cnt[i]++;
                        end
                    end
                end
            end
            case (tx_mode)
                0: txr = 1'b1;
                1: txr = ~txr;
                default: txr = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: owner of the transmitter, pending header, quiet-cycle count.
    int             m_owner, m_quiet, m_last, m_gid, m_c;
    bit             m_hdr, m_init, m_found, prev_busy;
    logic [NUM-1:0] e_rr;
    logic           e_v, e_to, e_busy;
    logic [7:0]     e_d;

    initial begin
        m_init = 1'b0;
        prev_busy = 1'b0;
        cyc = 0;
    end

    // Compare process: expected outputs from the model, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (m_init) begin
            e_rr = '0; e_v = 1'b0; e_d = 8'h00; e_to = 1'b0; e_busy = 1'b0;
            if (m_owner >= 0) begin
                e_busy = 1'b1;
                if (m_hdr) begin
                    e_v = 1'b1;
                    e_d = TB_TAG_BASE | 8'(m_gid);
                end else begin
                    e_v = rv[m_owner];
                    e_d = rd[8*m_owner +: 8];
                    e_rr[m_owner] = txr;
                    e_to = !rv[m_owner] && (m_quiet == T - 1);
                end
            end
            chk("req_ready", {28'h0, bus.req_ready}, {28'h0, e_rr});
            chk("tx_valid", {31'h0, bus.tx_valid}, {31'h0, e_v});
            chk("tx_data", {24'h0, bus.tx_data}, {24'h0, e_d});
            chk("busy", {31'h0, busy}, {31'h0, e_busy});
            chk("grant_id", {30'h0, gid}, 32'(m_gid));
            chk("timeout_pulse", {31'h0, to_p}, {31'h0, e_to});
            if (bus.tx_valid && txr) byte_log.push_back(bus.tx_data);
            if (busy && !prev_busy) grant_log.push_back(int'(gid));
            prev_busy = busy;
            if (to_p) to_cyc = cyc;
            if (rv[2] && bus.req_ready[2]) src2_cyc = cyc;
        end
        if (reset) begin
            m_init = 1'b1; m_owner = -1; m_hdr = 1'b0; m_quiet = 0;
            m_last = NUM - 1; m_gid = 0;
        end else if (m_init) begin
            if (m_owner < 0) begin
                if (|rv) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= NUM; k++) begin
                        m_c = (m_last + k) % NUM;
                        if (!m_found && rv[m_c]) begin
                            m_found = 1'b1;
                            m_owner = m_c;
                        end
                    end
                    m_gid = m_owner; m_last = m_owner; m_hdr = TAG_EN; m_quiet = 0;
                end
            end else if (m_hdr) begin
                if (txr) m_hdr = 1'b0;
            end else if (rv[m_owner] && txr) begin
                m_quiet = 0;
                if (rl[m_owner]) m_owner = -1;
            end else if (!rv[m_owner]) begin
                if (m_quiet == T - 1) m_owner = -1;
                else m_quiet++;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        flush_req = 1'b0;
        tx_mode = 0;
        reset = 1'b1;

        // Reset held two cycles while every source requests.
        for (int i = 0; i < NUM; i++) push(i, 8'(8'hE0 + i), 1'b1, 0);
        step();
        step();
        @(negedge clk);
        #1;
        chk("rst_req_ready", {28'h0, bus.req_ready}, 32'h0);
        chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_grant_id", {30'h0, gid}, 32'h0);
        flush_req = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Round-robin: two 2-byte packets per source, back to back.
        grant_log.delete();
        byte_log.delete();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NUM; s++) begin
                push(s, 8'(s * 16 + p * 2 + 1), 1'b0, 0);
                push(s, 8'(s * 16 + p * 2 + 2), 1'b1, 0);
            end
        drain(400);
        chk("rr_npkts", grant_log.size(), 32'd8);
        chk("rr_order0", 32'(grant_log[0]), 32'd0);
        chk("rr_order1", 32'(grant_log[1]), 32'd1);
        chk("rr_order2", 32'(grant_log[2]), 32'd2);
        chk("rr_order3", 32'(grant_log[3]), 32'd3);
        chk("rr_order4", 32'(grant_log[4]), 32'd0);

        // Backpressure with tx_ready toggling.
        tx_mode = 1;
        byte_log.delete();
        push(1, 8'h11, 1'b0, 0);
        push(1, 8'h22, 1'b0, 0);
        push(1, 8'h33, 1'b1, 0);
        drain(400);
        exp_q.delete();
        if (TAG_EN) exp_q.push_back(8'hA1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        chk_bytes("bp_bytes");

        // Timeout: source 2 stops mid-packet; sources 3 and 0 wait.
        tx_mode = 0;
        grant_log.delete();
        to_cyc = -1;
        src2_cyc = -1;
        push(2, 8'h77, 1'b0, 0);
        push(3, 8'h3C, 1'b1, 0);
        push(0, 8'h0C, 1'b1, 0);
        drain(400);
        chk("to_delay", 32'(to_cyc - src2_cyc), 32'd8);
        chk("to_grant0", 32'(grant_log[0]), 32'd2);
        chk("to_grant1", 32'(grant_log[1]), 32'd3);
        chk("to_grant2", 32'(grant_log[2]), 32'd0);

        // Single-byte packet from source 3.
        byte_log.delete();
        push(3, 8'h55, 1'b1, 0);
        drain(400);
        exp_q.delete();
        if (TAG_EN) exp_q.push_back(8'hA3);
        exp_q.push_back(8'h55);
        chk_bytes("tag_bytes");

        // Reset while byte 2 of a 4-byte packet is on the bus.
        byte_log.delete();
        for (int b = 0; b < 4; b++) push(2, 8'(8'hC1 + b), b == 3, 0);
        begin
            int c;
            c = 0;
            while (c < 100 && byte_log.size() < (TAG_EN ? 2 : 1)) begin
                step();
                c++;
            end
            chk("mid_started", {31'h0, c < 100}, 32'h1);
        end
        reset = 1'b1;
        flush_req = 1'b1;
        step();
        @(negedge clk);
        #1;
        chk("mid_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("mid_req_ready", {28'h0, bus.req_ready}, 32'h0);
        chk("mid_busy", {31'h0, busy}, 32'h0);
        chk("mid_grant_id", {30'h0, gid}, 32'h0);
        step();
        reset = 1'b0;
        grant_log.delete();
        push(2, 8'h2A, 1'b1, 0);
        push(0, 8'h0A, 1'b1, 0);
        drain(400);
        chk("mid_after0", 32'(grant_log[0]), 32'd0);
        chk("mid_after1", 32'(grant_log[1]), 32'd2);

        // Random traffic with random backpressure and occasional long gaps.
        tx_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int s, len;
            s = $urandom_range(0, NUM - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                push(s, 8'($urandom), b == len - 1,
                     ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 2));
        end
        drain(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
